// File: rtl/sound_wave_channel.sv
// Wave-table sound channel: NR30-NR34 registers, packed 4-bit wave RAM, frequency timer, length counter, PCM scaling.
// Optional define WAVE_RAM_LOCK_EN: while playing, CPU wave RAM access is redirected to the byte being played.
module sound_wave_channel #(
  parameter logic [15:0] REG_BASE   = 16'hFF1A,
  parameter logic [15:0] WAVE_BASE  = 16'hFF30,
  parameter int          WAVE_DEPTH = 16,
  parameter int          FREQ_BITS  = 11,
  parameter int          LEN_BITS   = 8,
  parameter int          OUT_WIDTH  = 20
) (
  input  logic                                I_CLK,
  input  logic                                I_RESET,
  input  logic                                I_TIMER_TICK,
  input  logic                                I_LEN_TICK,
  input  logic [15:0]                         I_IOREG_ADDR,
  inout  wire  [7:0]                          IO_IOREG_DATA,
  input  logic                                I_IOREG_WE_L,
  input  logic                                I_IOREG_RE_L,
  output logic                                O_CH_ON,
  output logic [OUT_WIDTH-1:0]                O_WAVEFORM,
  output logic [$clog2(2*WAVE_DEPTH)-1:0]     O_SAMPLE_PTR
);

  localparam int PTR_W  = $clog2(2*WAVE_DEPTH);
  localparam int ADDR_W = $clog2(WAVE_DEPTH);
  localparam logic [FREQ_BITS:0] TIMER_FULL = {1'b1, {FREQ_BITS{1'b0}}};
  localparam logic [LEN_BITS:0]  LEN_FULL   = {1'b1, {LEN_BITS{1'b0}}};
  localparam logic [OUT_WIDTH+3:0] MAX_LEVEL = (OUT_WIDTH+4)'((1 << (OUT_WIDTH-1)) - 1);

  logic                 dac_en;
  logic [1:0]           vol;
  logic [FREQ_BITS-1:0] freq;
  logic                 len_en;
  logic                 active;
  logic [LEN_BITS:0]    len;
  logic [FREQ_BITS:0]   timer;
  logic [PTR_W-1:0]     ptr;
  logic [7:0]           wave_ram [WAVE_DEPTH];

  logic                 wr, rd;
  logic [15:0]          reg_off, wave_off;
  logic                 reg_hit, wave_hit;
  logic [ADDR_W-1:0]    ram_idx;
  logic [7:0]           rdata;
  logic                 trig, len_load;
  logic [FREQ_BITS-1:0] trig_freq;
  logic [7:0]           play_byte;
  logic [3:0]           nibble, vs;
  logic [OUT_WIDTH+3:0] prod;
  logic [OUT_WIDTH-1:0] level;

  assign wr       = !I_IOREG_WE_L;
  assign rd       = !I_IOREG_RE_L;
  assign reg_off  = I_IOREG_ADDR - REG_BASE;
  assign wave_off = I_IOREG_ADDR - WAVE_BASE;
  assign reg_hit  = reg_off < 16'd5;
  assign wave_hit = wave_off < 16'(WAVE_DEPTH);

`ifdef WAVE_RAM_LOCK_EN
  assign ram_idx = active ? ptr[PTR_W-1:1] : wave_off[ADDR_W-1:0];
`else
  assign ram_idx = wave_off[ADDR_W-1:0];
`endif

  assign trig      = wr && reg_hit && reg_off[2:0] == 3'd4 && IO_IOREG_DATA[7];
  assign len_load  = wr && reg_hit && reg_off[2:0] == 3'd1;
  assign trig_freq = {IO_IOREG_DATA[FREQ_BITS-9:0], freq[7:0]};

  always_comb begin
    rdata = 8'hFF;
    if (wave_hit) rdata = wave_ram[ram_idx];
    else begin
      case (reg_off[2:0])
        3'd0:    rdata = {dac_en, 7'h7F};
        3'd2:    rdata = {1'b1, vol, 5'h1F};
        3'd4:    rdata = {1'b1, len_en, 6'h3F};
        default: rdata = 8'hFF;
      endcase
    end
  end

  assign IO_IOREG_DATA = (rd && (reg_hit || wave_hit)) ? rdata : 8'hzz;

  // Playback path reads the byte under the pointer; a same-cycle CPU write is seen one cycle later.
  assign play_byte = wave_ram[ptr[PTR_W-1:1]];
  assign nibble    = ptr[0] ? play_byte[3:0] : play_byte[7:4];

  always_comb begin
    case (vol)
      2'd0:    vs = 4'd0;
      2'd1:    vs = nibble;
      2'd2:    vs = nibble >> 1;
      default: vs = nibble >> 2;
    endcase
  end

  assign prod  = (OUT_WIDTH+4)'(vs) * MAX_LEVEL;
  assign level = OUT_WIDTH'(prod / (OUT_WIDTH+4)'(15));

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      dac_en     <= 1'b0;
      vol        <= 2'd0;
      freq       <= '0;
      len_en     <= 1'b0;
      active     <= 1'b0;
      len        <= '0;
      timer      <= '0;
      ptr        <= '0;
      O_WAVEFORM <= '0;
      for (int i = 0; i < WAVE_DEPTH; i++) wave_ram[i] <= 8'h00;
    end else begin
      O_WAVEFORM <= (active && dac_en) ? level : '0;

      if (I_TIMER_TICK && active && !trig) begin
        if (timer == (FREQ_BITS+1)'(1)) begin
          timer <= TIMER_FULL - {1'b0, freq};
          ptr   <= ptr + 1'b1;
        end else begin
          timer <= timer - 1'b1;
        end
      end

      if (I_LEN_TICK && len_en && len != '0 && !trig && !len_load) begin
        len <= len - 1'b1;
        if (len == (LEN_BITS+1)'(1)) active <= 1'b0;
      end

      if (wr && reg_hit) begin
        case (reg_off[2:0])
          3'd0: begin
            dac_en <= IO_IOREG_DATA[7];
            if (!IO_IOREG_DATA[7]) active <= 1'b0;
          end
          3'd1: len <= LEN_FULL - (LEN_BITS+1)'(IO_IOREG_DATA[LEN_BITS-1:0]);
          3'd2: vol <= IO_IOREG_DATA[6:5];
          3'd3: freq[7:0] <= IO_IOREG_DATA;
          3'd4: begin
            freq[FREQ_BITS-1:8] <= IO_IOREG_DATA[FREQ_BITS-9:0];
            len_en <= IO_IOREG_DATA[6];
            if (IO_IOREG_DATA[7]) begin
              if (dac_en) active <= 1'b1;
              timer <= TIMER_FULL - {1'b0, trig_freq};
              ptr   <= '0;
              if (len == '0) len <= LEN_FULL;
            end
          end
          default: ;
        endcase
      end

      if (wr && wave_hit) wave_ram[ram_idx] <= IO_IOREG_DATA;
    end
  end

  assign O_CH_ON      = active;
  assign O_SAMPLE_PTR = ptr;

endmodule

// File: tb/tb_sound_wave_channel.sv
// Self-checking bench for sound_wave_channel: per-cycle behavioural model plus directed literal checks.
module tb_sound_wave_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tt = 1'b0, lt = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        we_l = 1'b1, re_l = 1'b1;
  logic [7:0]  drv = 8'h00;
  logic        oe = 1'b0;
  wire  [7:0]  io;
  logic        ch_on;
  logic [19:0] wave;
  logic [4:0]  sptr;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign io = oe ? drv : 8'hzz;

  sound_wave_channel dut (
    .I_CLK(clk), .I_RESET(rst), .I_TIMER_TICK(tt), .I_LEN_TICK(lt),
    .I_IOREG_ADDR(addr), .IO_IOREG_DATA(io), .I_IOREG_WE_L(we_l), .I_IOREG_RE_L(re_l),
    .O_CH_ON(ch_on), .O_WAVEFORM(wave), .O_SAMPLE_PTR(sptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: plain integers, one update per rising edge.
  int m_ram [16];
  bit m_active, m_dac, m_len_en, m_valid;
  int m_vol, m_freq, m_len, m_timer, m_ptr, m_wave;

  function automatic int level_of(int n, int v);
    longint s;
    if (v == 0) return 0;
    s = longint'(n >> (v - 1));
    return int'((s * 524287) / 15);
  endfunction

  always @(posedge clk) begin
    bit old_active, is_trig, is_len_load, we;
    int old_ptr, a, d, nib, idx;
    if (rst) begin
      foreach (m_ram[i]) m_ram[i] = 0;
      m_active = 0; m_dac = 0; m_len_en = 0;
      m_vol = 0; m_freq = 0; m_len = 0; m_timer = 0; m_ptr = 0; m_wave = 0;
      m_valid = 1;
    end else begin
      old_active = m_active;
      old_ptr = m_ptr;
      nib = (m_ptr % 2 == 1) ? (m_ram[m_ptr / 2] & 15) : (m_ram[m_ptr / 2] >> 4);
      m_wave = (m_active && m_dac) ? level_of(nib, m_vol) : 0;
      we = !we_l;
      a = int'(addr);
      d = int'(drv);
      is_trig = we && a == 'hFF1E && d >= 128;
      is_len_load = we && a == 'hFF1B;
      if (tt && m_active && !is_trig) begin
        if (m_timer == 1) begin
          m_timer = 2048 - m_freq;
          m_ptr = (m_ptr + 1) % 32;
        end else m_timer--;
      end
      if (lt && m_len_en && m_len != 0 && !is_trig && !is_len_load) begin
        m_len--;
        if (m_len == 0) m_active = 0;
      end
      if (we) begin
        case (a)
          'hFF1A: begin m_dac = d >= 128; if (d < 128) m_active = 0; end
          'hFF1B: m_len = 256 - d;
          'hFF1C: m_vol = (d >> 5) & 3;
          'hFF1D: m_freq = (m_freq & 'h700) | d;
          'hFF1E: begin
            m_freq = (m_freq & 'hFF) | ((d & 7) << 8);
            m_len_en = ((d >> 6) & 1) == 1;
            if (is_trig) begin
              if (m_dac) m_active = 1;
              m_timer = 2048 - m_freq;
              m_ptr = 0;
              if (m_len == 0) m_len = 256;
            end
          end
          default: ;
        endcase
        if (a >= 'hFF30 && a <= 'hFF3F) begin
          idx = a - 'hFF30;
`ifdef WAVE_RAM_LOCK_EN
          if (old_active) idx = old_ptr / 2;
`endif
          m_ram[idx] = d;
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("model_wave", 32'(wave), 32'(m_wave));
      chk("model_ch_on", 32'(ch_on), 32'(m_active));
      chk("model_ptr", 32'(sptr), 32'(m_ptr));
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; drv = d; oe = 1'b1; we_l = 1'b0;
    @(negedge clk);
    we_l = 1'b1; oe = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a; re_l = 1'b0;
    #1 v = io;
    re_l = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(name, 32'(v), 32'(exp));
  endtask

  task automatic len_pulse();
    @(negedge clk); lt = 1'b1;
    @(negedge clk); lt = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and register read-back masks
    rd_chk("rst_nr30", 16'hFF1A, 8'h7F);
    rd_chk("rst_nr31", 16'hFF1B, 8'hFF);
    rd_chk("rst_nr32", 16'hFF1C, 8'h9F);
    rd_chk("rst_nr33", 16'hFF1D, 8'hFF);
    rd_chk("rst_nr34", 16'hFF1E, 8'hBF);
    chk("rst_wave", 32'(wave), 32'h0);
    chk("rst_ch_on", 32'(ch_on), 32'h0);
    @(negedge clk);
    addr = 16'hFF1A; drv = 8'h00; oe = 1'b1; re_l = 1'b1;
    #1 chk("bus_idle", 32'(io), 32'h00);
    oe = 1'b0;

    // Full volume, period 1: F then 0
    wr(16'hFF30, 8'hF0);
    wr(16'hFF1A, 8'h80);
    wr(16'hFF1C, 8'h20);
    wr(16'hFF1D, 8'hFF);
    wr(16'hFF1E, 8'h87);
    chk("trig_on", 32'(ch_on), 32'h1);
    tt = 1'b1;
    @(posedge clk); #1;
    chk("play_F", 32'(wave), 32'h7FFFF);
    chk("ptr1", 32'(sptr), 32'd1);
    @(posedge clk); #1;
    chk("play_0", 32'(wave), 32'h00000);
    chk("ptr2", 32'(sptr), 32'd2);
    @(negedge clk); tt = 1'b0;

    // Volume shifts on nibble F
    wr(16'hFF1C, 8'h40);
    wr(16'hFF1E, 8'h87);
    @(posedge clk); #1 chk("vol_half", 32'(wave), 32'h3BBBB);
    wr(16'hFF1C, 8'h60);
    @(posedge clk); #1 chk("vol_quarter", 32'(wave), 32'h19999);
    wr(16'hFF1C, 8'h00);
    @(posedge clk); #1 chk("vol_mute", 32'(wave), 32'h0);
    wr(16'hFF30, 8'h1F);
    wr(16'hFF1C, 8'h20);
    @(posedge clk); #1 chk("nibble_1", 32'(wave), 32'h08888);
    rd_chk("nr32_rb", 16'hFF1C, 8'hBF);

    // Length counter expiry
    wr(16'hFF1B, 8'hFE);
    wr(16'hFF1E, 8'hC7);
    len_pulse();
    chk("len_after1", 32'(ch_on), 32'h1);
    len_pulse();
    chk("len_after2", 32'(ch_on), 32'h0);
    rd_chk("nr34_rb", 16'hFF1E, 8'hFF);
    wr(16'hFF1B, 8'hFE);
    wr(16'hFF1E, 8'h87);
    repeat (3) len_pulse();
    chk("len_disabled", 32'(ch_on), 32'h1);

    // Trigger with DAC off keeps channel silent
    wr(16'hFF1A, 8'h00);
    chk("dac_off", 32'(ch_on), 32'h0);
    wr(16'hFF1E, 8'h87);
    chk("trig_dac_off", 32'(ch_on), 32'h0);
    wr(16'hFF1A, 8'h80);

    // Period 2 with pointer wrap
    wr(16'hFF1D, 8'hFE);
    wr(16'hFF1E, 8'h87);
    tt = 1'b1;
    repeat (62) @(posedge clk);
    #1 chk("ptr_31", 32'(sptr), 32'd31);
    @(posedge clk);
    @(posedge clk); #1 chk("ptr_wrap", 32'(sptr), 32'd0);
    @(negedge clk); tt = 1'b0;

    // Wave RAM CPU access while playing
    wr(16'hFF1A, 8'h00);
    wr(16'hFF33, 8'h3C);
    wr(16'hFF30, 8'h11);
    wr(16'hFF1A, 8'h80);
    wr(16'hFF1D, 8'hFF);
    wr(16'hFF1E, 8'h87);
    tt = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); tt = 1'b0;
    chk("lock_ptr6", 32'(sptr), 32'd6);
`ifdef WAVE_RAM_LOCK_EN
    rd_chk("lock_rd", 16'hFF3A, 8'h3C);
    wr(16'hFF30, 8'hAB);
    rd_chk("lock_rd2", 16'hFF35, 8'hAB);
    wr(16'hFF1A, 8'h00);
    rd_chk("lock_ram0", 16'hFF30, 8'h11);
    rd_chk("lock_ram3", 16'hFF33, 8'hAB);
`else
    rd_chk("ram_rd3", 16'hFF33, 8'h3C);
    wr(16'hFF3A, 8'h5C);
    rd_chk("ram_rd10", 16'hFF3A, 8'h5C);
    rd_chk("ram_rd0", 16'hFF30, 8'h11);
`endif

    // Reset during playback
    wr(16'hFF1A, 8'h80);
    wr(16'hFF1E, 8'h87);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst2_ch_on", 32'(ch_on), 32'h0);
    rd_chk("rst2_nr30", 16'hFF1A, 8'h7F);
    rd_chk("rst2_ram", 16'hFF30, 8'h00);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
